// File: rtl/spi_slave_pkg.sv
// Shared constants and types for the SPI target peripheral:
// register offsets, STATUS layout and FSM state encoding.
package spi_slave_pkg;

    localparam int unsigned ADDR_W = 8;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned BYTE_W = 8;
    localparam int unsigned FRAME_W = 16;

    localparam logic [ADDR_W-1:0] REG_CTRL   = 8'h00;
    localparam logic [ADDR_W-1:0] REG_DUMMY  = 8'h04;
    localparam logic [ADDR_W-1:0] REG_STATUS = 8'h08;
    localparam logic [ADDR_W-1:0] REG_TX     = 8'h0C;
    localparam logic [ADDR_W-1:0] REG_RX     = 8'h10;
    localparam logic [ADDR_W-1:0] REG_FRAMES = 8'h14;

    localparam int unsigned CTRL_ENABLE    = 0;
    localparam int unsigned CTRL_RX_IRQ_EN = 1;

    localparam int unsigned STAT_TX_EMPTY = 0;
    localparam int unsigned STAT_TX_FULL  = 1;
    localparam int unsigned STAT_RX_EMPTY = 2;
    localparam int unsigned STAT_RX_FULL  = 3;
    localparam int unsigned STAT_SELECTED = 4;
    localparam int unsigned STAT_OVERRUN  = 5;
    localparam int unsigned STAT_UNDERRUN = 6;
    localparam int unsigned STAT_W        = 7;

    // STATUS payload, MSB first to match the bit indices above
    typedef struct packed {
        logic underrun;
        logic overrun;
        logic selected;
        logic rx_full;
        logic rx_empty;
        logic tx_full;
        logic tx_empty;
    } status_t;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_e;

endpackage

// File: rtl/fifo.sv
// Synchronous first-word-fall-through FIFO; dout is valid whenever !empty.
// Pushes while full and pops while empty are ignored.
module fifo #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned DEPTH      = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] din,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  full,
    output logic                  empty
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         count_q, count_d;
    logic                  do_wr;
    logic                  do_rd;

    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);
    assign dout  = mem_q[rd_ptr_q];
    assign do_wr = wr_en && !full;
    assign do_rd = rd_en && !empty;

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
    endfunction

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q + CW'(do_wr) - CW'(do_rd);
        if (do_wr) wr_ptr_d = ptr_inc(wr_ptr_q);
        if (do_rd) rd_ptr_d = ptr_inc(rd_ptr_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage carries no reset; contents are qualified by count_q
    always_ff @(posedge clk) begin
        if (do_wr) mem_q[wr_ptr_q] <= din;
    end

endmodule

// File: rtl/spi_slave_sync.sv
// Two-flop synchronizer for an asynchronous SPI pin plus a history flop
// giving single-cycle rise/fall pulses on the synchronized level.
module spi_slave_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic dout,
    output logic rise_c,
    output logic fall_c
);

    logic meta_q, meta_d;
    logic sync_q, sync_d;
    logic hist_q, hist_d;

    always_comb begin
        meta_d = din;
        sync_d = meta_q;
        hist_d = sync_q;
    end

    // Reset to 0 so a pin already low at reset release never looks like a fall
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            hist_q <= 1'b0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
            hist_q <= hist_d;
        end
    end

    assign dout   = sync_q;
    assign rise_c = sync_q & ~hist_q;
    assign fall_c = ~sync_q & hist_q;

endmodule

// File: rtl/spi_slave.sv
// Memory-mapped SPI target, mode 0, MSB first. Oversamples SCLK/MOSI/CS
// with clk and buffers bytes in TX/RX FIFOs behind a small register file.
module spi_slave
    import spi_slave_pkg::*;
#(
    parameter int unsigned FIFO_TX_DEPTH = 8,
    parameter int unsigned FIFO_RX_DEPTH = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] address,
    input  logic [DATA_W-1:0] write_data,
    output logic [DATA_W-1:0] read_data,
    input  logic              we,
    input  logic              re,
    input  logic              spi_clk,
    input  logic              spi_mosi,
    input  logic              spi_cs,
    output logic              spi_miso,
    output logic              spi_miso_oe,
    output logic              irq
);

    state_e               state_q, state_d;
    logic [2:0]           bit_cnt_q, bit_cnt_d;
    logic [BYTE_W-1:0]    shreg_q, shreg_d;
    logic [BYTE_W-1:0]    rx_shift_q, rx_shift_d;
    logic [BYTE_W-1:0]    tx_next_q, tx_next_d;
    logic                 reload_q, reload_d;
    logic                 miso_q, miso_d;
    logic                 miso_oe_q, miso_oe_d;
    logic                 enable_q, enable_d;
    logic                 rx_irq_en_q, rx_irq_en_d;
    logic [BYTE_W-1:0]    dummy_q, dummy_d;
    logic                 underrun_q, underrun_d;
    logic                 overrun_q, overrun_d;
    logic [FRAME_W-1:0]   frames_q, frames_d;
    logic                 mosi_meta_q, mosi_meta_d;
    logic                 mosi_s_q, mosi_s_d;

    logic                 sclk_rise, sclk_fall, sclk_lvl_unused;
    logic                 cs_s, cs_rise, cs_fall;
    logic                 tx_empty, tx_full, tx_push, tx_pop;
    logic [BYTE_W-1:0]    tx_dout;
    logic                 rx_empty, rx_full, rx_push, rx_pop;
    logic [BYTE_W-1:0]    rx_dout, rx_byte, fetch_byte;
    logic                 ctrl_wr, status_wr, disable_wr;
    status_t              status;
    logic                 wdata_unused;

    spi_slave_sync u_sync_sclk (
        .clk    (clk),
        .rst_n  (rst_n),
        .din    (spi_clk),
        .dout   (sclk_lvl_unused),
        .rise_c (sclk_rise),
        .fall_c (sclk_fall)
    );

    spi_slave_sync u_sync_cs (
        .clk    (clk),
        .rst_n  (rst_n),
        .din    (spi_cs),
        .dout   (cs_s),
        .rise_c (cs_rise),
        .fall_c (cs_fall)
    );

    fifo #(.DATA_WIDTH(BYTE_W), .DEPTH(FIFO_TX_DEPTH)) u_tx_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .wr_en (tx_push),
        .din   (write_data[BYTE_W-1:0]),
        .rd_en (tx_pop),
        .dout  (tx_dout),
        .full  (tx_full),
        .empty (tx_empty)
    );

    fifo #(.DATA_WIDTH(BYTE_W), .DEPTH(FIFO_RX_DEPTH)) u_rx_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .wr_en (rx_push),
        .din   (rx_byte),
        .rd_en (rx_pop),
        .dout  (rx_dout),
        .full  (rx_full),
        .empty (rx_empty)
    );

    assign ctrl_wr      = we && (address == REG_CTRL);
    assign status_wr    = we && (address == REG_STATUS);
    assign disable_wr   = ctrl_wr && !write_data[CTRL_ENABLE];
    assign tx_push      = we && (address == REG_TX);
    assign rx_pop       = re && (address == REG_RX);
    assign rx_byte      = {rx_shift_q[BYTE_W-2:0], mosi_s_q};
    assign fetch_byte   = tx_empty ? dummy_q : tx_dout;
    assign wdata_unused = ^write_data[DATA_W-1:BYTE_W];

    // Register writes first, then FSM, so sticky set events override W1C
    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        shreg_d     = shreg_q;
        rx_shift_d  = rx_shift_q;
        tx_next_d   = tx_next_q;
        reload_d    = reload_q;
        miso_d      = miso_q;
        miso_oe_d   = miso_oe_q;
        enable_d    = enable_q;
        rx_irq_en_d = rx_irq_en_q;
        dummy_d     = dummy_q;
        underrun_d  = underrun_q;
        overrun_d   = overrun_q;
        frames_d    = frames_q;
        mosi_meta_d = spi_mosi;
        mosi_s_d    = mosi_meta_q;
        tx_pop      = 1'b0;
        rx_push     = 1'b0;

        if (we) begin
            case (address)
                REG_CTRL: begin
                    enable_d    = write_data[CTRL_ENABLE];
                    rx_irq_en_d = write_data[CTRL_RX_IRQ_EN];
                end
                REG_DUMMY:  dummy_d  = write_data[BYTE_W-1:0];
                REG_FRAMES: frames_d = '0;
                default: ;
            endcase
        end
        if (status_wr && write_data[STAT_UNDERRUN]) underrun_d = 1'b0;
        if (status_wr && write_data[STAT_OVERRUN])  overrun_d  = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (cs_fall && enable_q && !disable_wr) begin
                    state_d    = ST_SHIFT;
                    bit_cnt_d  = '0;
                    rx_shift_d = '0;
                    reload_d   = 1'b0;
                    shreg_d    = fetch_byte;
                    miso_d     = fetch_byte[BYTE_W-1];
                    miso_oe_d  = 1'b1;
                    tx_pop     = !tx_empty;
                    if (tx_empty) underrun_d = 1'b1;
                end
            end
            ST_SHIFT: begin
                if (cs_rise || disable_wr) begin
                    state_d   = ST_IDLE;
                    bit_cnt_d = '0;
                    reload_d  = 1'b0;
                    miso_d    = 1'b0;
                    miso_oe_d = 1'b0;
                end else if (sclk_rise) begin
                    rx_shift_d = rx_byte;
                    bit_cnt_d  = bit_cnt_q + 3'd1;
                    // Eighth bit: byte complete, prefetch the next TX byte
                    if (bit_cnt_q == 3'd7) begin
                        rx_push   = 1'b1;
                        frames_d  = frames_d + FRAME_W'(1);
                        tx_next_d = fetch_byte;
                        reload_d  = 1'b1;
                        tx_pop    = !tx_empty;
                        if (rx_full)  overrun_d  = 1'b1;
                        if (tx_empty) underrun_d = 1'b1;
                    end
                end else if (sclk_fall) begin
                    if (reload_q) begin
                        shreg_d  = tx_next_q;
                        reload_d = 1'b0;
                    end else begin
                        shreg_d = {shreg_q[BYTE_W-2:0], 1'b0};
                    end
                    miso_d = shreg_d[BYTE_W-1];
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            bit_cnt_q   <= '0;
            shreg_q     <= '0;
            rx_shift_q  <= '0;
            tx_next_q   <= '0;
            reload_q    <= 1'b0;
            miso_q      <= 1'b0;
            miso_oe_q   <= 1'b0;
            enable_q    <= 1'b1;
            rx_irq_en_q <= 1'b0;
            dummy_q     <= 8'hFF;
            underrun_q  <= 1'b0;
            overrun_q   <= 1'b0;
            frames_q    <= '0;
            mosi_meta_q <= 1'b0;
            mosi_s_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shreg_q     <= shreg_d;
            rx_shift_q  <= rx_shift_d;
            tx_next_q   <= tx_next_d;
            reload_q    <= reload_d;
            miso_q      <= miso_d;
            miso_oe_q   <= miso_oe_d;
            enable_q    <= enable_d;
            rx_irq_en_q <= rx_irq_en_d;
            dummy_q     <= dummy_d;
            underrun_q  <= underrun_d;
            overrun_q   <= overrun_d;
            frames_q    <= frames_d;
            mosi_meta_q <= mosi_meta_d;
            mosi_s_q    <= mosi_s_d;
        end
    end

    always_comb begin
        status          = '0;
        status.underrun = underrun_q;
        status.overrun  = overrun_q;
        status.selected = !cs_s && enable_q;
        status.rx_full  = rx_full;
        status.rx_empty = rx_empty;
        status.tx_full  = tx_full;
        status.tx_empty = tx_empty;
    end

    // Bus read mux; unmapped and write-only offsets read as zero
    always_comb begin
        read_data = '0;
        case (address)
            REG_CTRL:   read_data = {30'd0, rx_irq_en_q, enable_q};
            REG_DUMMY:  read_data = {24'd0, dummy_q};
            REG_STATUS: read_data = {(DATA_W - STAT_W)'(0), status};
            REG_RX:     read_data = {24'd0, rx_dout};
            REG_FRAMES: read_data = {16'd0, frames_q};
            default:    read_data = '0;
        endcase
    end

    assign spi_miso    = miso_q;
    assign spi_miso_oe = miso_oe_q;
    assign irq         = rx_irq_en_q & ~rx_empty;

endmodule

// File: tb/tb_spi_slave.sv
// Randomized scoreboard bench for spi_slave: a queue-based model of the
// register file and FIFOs predicts bus reads, MISO bytes and pin states.
module tb_spi_slave;

    localparam int HALF = 8;
    localparam int DEPTH = 8;
    localparam logic [7:0] A_CTRL = 8'h00, A_DUMMY = 8'h04, A_STATUS = 8'h08;
    localparam logic [7:0] A_TX = 8'h0C, A_RX = 8'h10, A_FRAMES = 8'h14;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  address = '0;
    logic [31:0] write_data = '0;
    logic [31:0] read_data;
    logic        we = 1'b0, re = 1'b0;
    logic        spi_clk = 1'b0, spi_mosi = 1'b0, spi_cs = 1'b1;
    logic        spi_miso, spi_miso_oe, irq;

    spi_slave #(.FIFO_TX_DEPTH(DEPTH), .FIFO_RX_DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .address(address), .write_data(write_data),
        .read_data(read_data), .we(we), .re(re), .spi_clk(spi_clk),
        .spi_mosi(spi_mosi), .spi_cs(spi_cs), .spi_miso(spi_miso),
        .spi_miso_oe(spi_miso_oe), .irq(irq)
    );

    always #5 clk = ~clk;

    // Scoreboard queues: expectations pushed by stimulus, observations by the master
    logic [31:0] exp_rd_q[$];
    string       exp_rd_nm_q[$];
    logic [7:0]  exp_miso_q[$], obs_miso_q[$];
    logic [2:0]  exp_pin_q[$], obs_pin_q[$];
    string       pin_nm_q[$];
    int          n_vec = 0, n_miss = 0;
    logic        done = 1'b0, final_chk = 1'b0;
    logic [7:0]  mosi_buf[16];

    // Reference model state
    logic [7:0]  m_tx[$], m_rx[$];
    logic [7:0]  m_dummy;
    logic [15:0] m_frames;
    logic        m_en, m_irq_en, m_underrun, m_overrun;

    always @(negedge clk) begin : monitor
        logic [31:0] e32;
        logic [7:0]  e8, o8;
        logic [2:0]  e3, o3;
        string       nm;
        if (re) begin
            n_vec++;
            if (exp_rd_q.size() == 0) begin
                n_miss++;
                $display("FAIL bus_read_unexpected: got %08h, nothing expected", read_data);
            end else begin
                e32 = exp_rd_q.pop_front();
                nm  = exp_rd_nm_q.pop_front();
                if (read_data !== e32) begin
                    n_miss++;
                    $display("FAIL %s: got %08h, expected %08h", nm, read_data, e32);
                end
            end
        end
        while (obs_miso_q.size() > 0) begin
            o8 = obs_miso_q.pop_front();
            n_vec++;
            if (exp_miso_q.size() == 0) begin
                n_miss++;
                $display("FAIL miso_unexpected: got %02h, nothing expected", o8);
            end else begin
                e8 = exp_miso_q.pop_front();
                if (o8 !== e8) begin
                    n_miss++;
                    $display("FAIL miso_byte: got %02h, expected %02h", o8, e8);
                end
            end
        end
        while (obs_pin_q.size() > 0) begin
            o3 = obs_pin_q.pop_front();
            e3 = exp_pin_q.pop_front();
            nm = pin_nm_q.pop_front();
            n_vec++;
            if (o3 !== e3) begin
                n_miss++;
                $display("FAIL %s {oe,miso,irq}: got %03b, expected %03b", nm, o3, e3);
            end
        end
        if (done && !final_chk) begin
            final_chk = 1'b1;
            n_vec++;
            if (exp_miso_q.size() != 0 || exp_rd_q.size() != 0) begin
                n_miss++;
                $display("FAIL leftover_expectations: miso %0d, reads %0d, expected 0 and 0",
                         exp_miso_q.size(), exp_rd_q.size());
            end
        end
    end

    initial begin
        #800000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic m_reset();
        m_tx.delete();
        m_rx.delete();
        m_dummy = 8'hFF;
        m_frames = '0;
        m_en = 1'b1;
        m_irq_en = 1'b0;
        m_underrun = 1'b0;
        m_overrun = 1'b0;
    endtask

    function automatic logic [7:0] m_fetch();
        if (m_tx.size() > 0) return m_tx.pop_front();
        m_underrun = 1'b1;
        return m_dummy;
    endfunction

    function automatic logic [31:0] m_status(input logic sel);
        return {25'd0, m_underrun, m_overrun, sel, m_rx.size() == DEPTH,
                m_rx.size() == 0, m_tx.size() == DEPTH, m_tx.size() == 0};
    endfunction

    function automatic logic m_irq();
        return m_irq_en && (m_rx.size() > 0);
    endfunction

    task automatic wr(input logic [7:0] a, input logic [31:0] d);
        address = a;
        write_data = d;
        we = 1'b1;
        step(1);
        we = 1'b0;
    endtask

    task automatic rd(input logic [7:0] a, input logic [31:0] e, input string nm);
        exp_rd_q.push_back(e);
        exp_rd_nm_q.push_back(nm);
        address = a;
        re = 1'b1;
        step(1);
        re = 1'b0;
    endtask

    task automatic pins(input logic oe, input logic mi, input logic iq, input string nm);
        exp_pin_q.push_back({oe, mi, iq});
        pin_nm_q.push_back(nm);
        obs_pin_q.push_back({spi_miso_oe, spi_miso, irq});
    endtask

    task automatic tx_push(input logic [7:0] b);
        wr(A_TX, {24'd0, b});
        if (m_tx.size() < DEPTH) m_tx.push_back(b);
    endtask

    task automatic wr_ctrl(input logic [1:0] v);
        wr(A_CTRL, {30'd0, v});
        m_en = v[0];
        m_irq_en = v[1];
    endtask

    task automatic wr_status(input logic [31:0] v);
        wr(A_STATUS, v);
        if (v[6]) m_underrun = 1'b0;
        if (v[5]) m_overrun = 1'b0;
    endtask

    task automatic wr_dummy(input logic [7:0] v);
        wr(A_DUMMY, {24'd0, v});
        m_dummy = v;
    endtask

    task automatic wr_frames();
        wr(A_FRAMES, 32'hDEAD_BEEF);
        m_frames = '0;
    endtask

    task automatic rd_status(input string nm);
        rd(A_STATUS, m_status(1'b0), nm);
    endtask

    task automatic drain_rx();
        while (m_rx.size() > 0) rd(A_RX, {24'd0, m_rx.pop_front()}, "rx_data");
    endtask

    // Master: nbytes whole bytes from mosi_buf, then pbits of a partial byte, then CS high
    task automatic spi_frame(input int nbytes, input int pbits);
        logic [7:0] outs[$];
        logic [7:0] rb;
        logic       pre_irq, en, first_bit;
        int         nb_tot, bits;
        pre_irq = m_irq();
        en = m_en;
        first_bit = 1'b0;
        if (en) begin
            outs.push_back(m_fetch());
            for (int k = 0; k < nbytes; k++) begin
                if (m_rx.size() < DEPTH) m_rx.push_back(mosi_buf[k]);
                else m_overrun = 1'b1;
                m_frames = m_frames + 16'd1;
                outs.push_back(m_fetch());
            end
            for (int k = 0; k < nbytes; k++) exp_miso_q.push_back(outs[k]);
            rb = outs[0];
            first_bit = rb[7];
        end
        spi_cs = 1'b0;
        step(HALF);
        pins(en, first_bit, pre_irq, "frame_start");
        nb_tot = nbytes + ((pbits > 0) ? 1 : 0);
        for (int b = 0; b < nb_tot; b++) begin
            bits = (b < nbytes) ? 8 : pbits;
            rb = '0;
            for (int i = 0; i < bits; i++) begin
                spi_mosi = mosi_buf[b][7-i];
                step(HALF);
                spi_clk = 1'b1;
                rb = {rb[6:0], spi_miso};
                step(HALF);
                spi_clk = 1'b0;
            end
            if (b < nbytes && en) obs_miso_q.push_back(rb);
        end
        step(HALF);
        spi_mosi = 1'b0;
        spi_cs = 1'b1;
        step(8);
        pins(1'b0, 1'b0, m_irq(), "frame_end");
    endtask

    initial begin : stimulus
        logic [15:0] saved_frames;
        int nb, pb, ntx;
        m_reset();
        step(3);
        rst_n = 1'b1;
        step(5);

        pins(1'b0, 1'b0, 1'b0, "reset_pins");
        rd(A_CTRL, 32'h1, "reset_ctrl");
        rd(A_DUMMY, 32'hFF, "reset_dummy");
        rd_status("reset_status");
        rd(A_FRAMES, 32'h0, "reset_frames");
        rd(8'h18, 32'h0, "unmapped");

        // Two bytes each way in one frame
        tx_push(8'hA5);
        tx_push(8'h3C);
        mosi_buf[0] = 8'h12;
        mosi_buf[1] = 8'h34;
        spi_frame(2, 0);
        drain_rx();
        rd(A_FRAMES, {16'd0, m_frames}, "frames_two");
        rd_status("status_after_two");

        // Underrun with programmed DUMMY, then W1C
        wr_status(32'h60);
        wr_dummy(8'h5A);
        mosi_buf[0] = 8'hFF;
        spi_frame(1, 0);
        rd_status("status_underrun");
        wr_status(32'h40);
        rd_status("status_underrun_clr");
        drain_rx();

        // Nine bytes into an 8-deep RX FIFO
        wr_ctrl(2'b11);
        for (int k = 0; k < 9; k++) mosi_buf[k] = 8'(k);
        spi_frame(9, 0);
        rd_status("status_overrun");
        drain_rx();
        wr_status(32'h60);
        rd_status("status_clear_all");

        // Partial byte aborted by CS, then a clean frame
        saved_frames = m_frames;
        mosi_buf[0] = 8'hF0;
        spi_frame(0, 4);
        rd(A_FRAMES, {16'd0, saved_frames}, "frames_after_partial");
        rd_status("status_after_partial");
        tx_push(8'hC3);
        mosi_buf[0] = 8'h96;
        spi_frame(1, 0);
        drain_rx();

        // Disabled: frame ignored
        wr_frames();
        wr_ctrl(2'b00);
        mosi_buf[0] = 8'h77;
        spi_frame(1, 0);
        rd(A_FRAMES, 32'h0, "frames_disabled");
        rd_status("status_disabled");
        wr_ctrl(2'b01);

        for (int it = 0; it < 10; it++) begin
            ntx = int'($urandom_range(0, 3));
            for (int j = 0; j < ntx; j++) tx_push(8'($urandom_range(0, 255)));
            if ($urandom_range(0, 1) == 1) wr_dummy(8'($urandom_range(0, 255)));
            if ($urandom_range(0, 2) == 0)
                wr_ctrl({1'($urandom_range(0, 1)), 1'($urandom_range(0, 4) != 0)});
            nb = int'($urandom_range(1, 3));
            pb = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 7)) : 0;
            for (int k = 0; k < 4; k++) mosi_buf[k] = 8'($urandom);
            spi_frame(nb, pb);
            rd_status("rand_status");
            rd(A_FRAMES, {16'd0, m_frames}, "rand_frames");
            if ($urandom_range(0, 1) == 1) drain_rx();
            if ($urandom_range(0, 2) == 0) wr_status(32'h60);
            if ($urandom_range(0, 4) == 0) wr_frames();
        end
        wr_ctrl(2'b11);
        drain_rx();

        // Leave state behind, then reset mid-frame with CS held low through release
        mosi_buf[0] = 8'h81;
        spi_frame(1, 0);
        spi_cs = 1'b0;
        step(HALF);
        for (int i = 0; i < 3; i++) begin
            spi_clk = 1'b1;
            step(HALF);
            spi_clk = 1'b0;
            step(HALF);
        end
        rst_n = 1'b0;
        step(1);
        pins(1'b0, 1'b0, 1'b0, "midframe_reset_pins");
        step(2);
        rst_n = 1'b1;
        m_reset();
        step(6);
        pins(1'b0, 1'b0, 1'b0, "cs_low_thru_reset");
        spi_mosi = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step(HALF);
            spi_clk = 1'b1;
            step(HALF);
            spi_clk = 1'b0;
        end
        rd(A_FRAMES, 32'h0, "frames_no_cs_fall");
        rd(A_STATUS, m_status(1'b1), "status_selected");
        spi_mosi = 1'b0;
        spi_cs = 1'b1;
        step(8);
        rd(A_CTRL, 32'h1, "post_reset_ctrl");
        rd(A_DUMMY, 32'hFF, "post_reset_dummy");
        rd_status("post_reset_status");
        rd(A_FRAMES, 32'h0, "post_reset_frames");

        done = 1'b1;
        step(3);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/spi_slave.md
Name: spi_slave

Overview:
- Memory-mapped SPI target (slave) peripheral on the same 8-bit-address peripheral bus as the SPI master peripheral.
- An external master drives SCLK, MOSI and CS. The block oversamples these with clk, shifts bytes in and out in mode 0 (CPOL=0, CPHA=0), MSB first.
- It buffers traffic in TX/RX FIFOs and raises an interrupt when received data is pending.

Parameters:
FIFO_TX_DEPTH, 8, depth of the byte FIFO holding bytes to send on MISO
FIFO_RX_DEPTH, 8, depth of the byte FIFO holding bytes received on MOSI

Ports:
clk  in  1  system clock
rst_n  in  1  reset, asynchronous, active-low
address  in  8  register byte offset
write_data  in  32  bus write data
read_data  out  32  bus read data (combinational from address)
we  in  1  write strobe, one cycle
re  in  1  read strobe, one cycle
spi_clk  in  1  SCLK from external master (asynchronous)
spi_mosi  in  1  MOSI from master (asynchronous)
spi_cs  in  1  chip select from master, active-low (asynchronous)
spi_miso  out  1  MISO data
spi_miso_oe  out  1  MISO output enable; 1 only while selected and enabled
irq  out  1  rx_irq_en & !rx_empty

Behaviour:
- Clocking and reset: clock clk; reset rst_n, asynchronous, active-low. Reset values: spi_miso=0, spi_miso_oe=0, irq=0.
- Input synchronisation: spi_clk, spi_mosi and spi_cs each pass through a 2-FF synchronizer, plus one history flop for edge detection.
  - Edge detect latency: 3 clk cycles.
  - SCLK high and low phases must each be >= 4 clk cycles; faster SCLK is unsupported.
- Register map (read_data is 0 for unmapped offsets):
  - 0x00 CTRL: bit0 enable (reset 1), bit1 rx_irq_en (reset 0). Read/write.
  - 0x04 DUMMY: [7:0] byte sent on TX underrun. Reset 0xFF.
  - 0x08 STATUS: {25'd0, underrun, overrun, selected, rx_full, rx_empty, tx_full, tx_empty}.
    - Bits 6:5 are sticky and write-1-to-clear.
    - selected = synchronized CS low && enable.
  - 0x0C TX: write pushes write_data[7:0]. The push is dropped silently if the TX FIFO is full.
  - 0x10 RX: read returns {24'd0, rx head}. re at this offset pops one entry; no pop when the FIFO is empty.
  - 0x14 FRAMES: [15:0] count of completed bytes. Wraps 0xFFFF->0. Any write clears it.
- FIFOs are first-word-fall-through: dout is valid whenever !empty.
- State machine, two states:
  - IDLE -> SHIFT on synced CS falling edge while enable=1.
    - On entry: bit_cnt=0; shreg is loaded from the TX head (pop), or from DUMMY if the TX FIFO is empty (set underrun).
    - spi_miso = shreg[7] in the same cycle; spi_miso_oe=1.
  - SHIFT, rising SCLK edge: rx_shift = {rx_shift[6:0], mosi}, then bit_cnt++.
    - On the 8th rise (bit_cnt 7->0) the byte is complete:
      - Push rx byte; if rx_full, drop the byte and set overrun.
      - FRAMES++.
      - Fetch the next tx byte into tx_next: pop the TX FIFO, or use DUMMY and set underrun. Set reload flag.
  - SHIFT, falling SCLK edge:
    - If reload is set: shreg <= tx_next and clear reload.
    - Otherwise: shreg <= shreg<<1.
    - spi_miso follows shreg[7]. MISO changes only on a CS fall or an SCLK fall.
  - SHIFT -> IDLE on synced CS rising edge, or when enable is written 0.
    - A partial rx byte is discarded.
    - Already-popped tx bytes (shreg, tx_next) are lost.
    - spi_miso_oe=0, spi_miso=0.
- Simultaneous events:
  - Bus pop of RX and a shift-in push in the same cycle: both occur (FIFO handles concurrent rd/wr).
  - Bus W1C of a sticky flag and the same flag's set event in the same cycle: set wins.
  - A write to TX in the same cycle as a TX pop: both occur.
- SCLK edges while in IDLE are ignored. A CS low held through reset deassertion does not start a frame; a CS falling edge is required.

Decomposition:
- Shared constants package: register offsets (CTRL/DUMMY/STATUS/TX/RX/FRAMES), STATUS bit indices, state encodings.
- Reuse the existing fifo module twice (DATA_WIDTH 8).
- One new sub-module, spi_slave_sync: 2-FF synchronizer plus rise/fall edge detect, instantiated for SCLK and CS; MOSI uses the sync stage only.

Test Plan:
- Push 0xA5, 0x3C to TX; master sends 0x12, 0x34 in one CS frame (SCLK = clk/16) -> master receives 0xA5, 0x3C; RX reads 0x12 then 0x34; FRAMES=2; rx_empty=1 afterwards.
- TX empty, DUMMY=0x5A; master clocks 1 byte 0xFF -> MISO carries 0x5A; underrun=1; write STATUS 0x40 -> underrun=0.
- RX depth 8; master sends 9 bytes 0x00..0x08 without bus reads -> RX holds 0x00..0x07; overrun=1; rx_full=1; irq=1 when rx_irq_en=1.
- CS rises after 4 SCLK periods of byte 0xF0 -> no RX push; FRAMES unchanged; spi_miso_oe=0; next frame starts at bit 7 correctly.
- CTRL.enable=0; master clocks 0x77 -> no RX push; spi_miso_oe stays 0; FRAMES=0.
- Assert rst_n low mid-frame -> all outputs 0; CTRL=0x1, DUMMY=0xFF, FRAMES=0, FIFOs empty, sticky flags 0.
